// File: rtl/trig_mon_pkg.sv
// trig_mon_pkg: shared FSM type and constants for the
// trigger activation monitor and its history buffer.
// Optional feature macro (top level): TRIG_MON_EVENT_CNT_EN.
package trig_mon_pkg;

  localparam int STATE_W        = 128;
  localparam int DEF_HIST_DEPTH = 4;
  localparam int DEF_CNT_W      = 32;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    CAPTURED = 2'd1,
    DUMP     = 2'd2
  } mon_state_e;

endpackage

// File: rtl/trig_hist_buf.sv
// trig_hist_buf: circular history of AES states with
// write pointer, saturating fill count and freeze.
// Ports: clk, rst (sync, active-high), clr (empties),
//   freeze (blocks writes), wr_en/wr_data (new state),
//   rd_off (offset from oldest entry), rd_data, fill.
module trig_hist_buf
  import trig_mon_pkg::*;
#(
  parameter int DEPTH = DEF_HIST_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       freeze,
  input  logic                       wr_en,
  input  logic [STATE_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_off,
  output logic [STATE_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;

  logic [STATE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PW-1:0]      oldest;
  logic [PW-1:0]      rd_idx;
  logic               wr_ok;

  assign wr_ok = wr_en && !freeze && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (fill_q != FW'(DEPTH))
        fill_d = fill_q + FW'(1);
    end
    if (clr) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Contents need no reset: fill gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem_q[wr_ptr_q] <= wr_data;
  end

  // DEPTH is a power of two, so pointer arithmetic
  // wraps for free; a full buffer gives oldest = wr_ptr.
  assign oldest  = wr_ptr_q - fill_q[PW-1:0];
  assign rd_idx  = oldest + rd_off;
  assign rd_data = mem_q[rd_idx];
  assign fill    = fill_q;

endmodule

// File: rtl/trig_activation_monitor.sv
// trig_activation_monitor: timestamps the first trigger
// edge, freezes recent AES states, dumps them on request.
// Ports: clk, rst (sync, active-high), state_in/state_vld,
//   trig_in, clr (re-arm), dump_start, out_data/out_vld/
//   out_rdy/out_last (dump stream), alarm, trig_stamp,
//   fill, busy; trig_events when TRIG_MON_EVENT_CNT_EN.
module trig_activation_monitor
  import trig_mon_pkg::*;
#(
  parameter int HIST_DEPTH = DEF_HIST_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [STATE_W-1:0]            state_in,
  input  logic                          state_vld,
  input  logic                          trig_in,
  input  logic                          clr,
  input  logic                          dump_start,
  output logic [STATE_W-1:0]            out_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic                          out_last,
  output logic                          alarm,
  output logic [CNT_W-1:0]              trig_stamp,
  output logic [$clog2(HIST_DEPTH):0]   fill,
  output logic                          busy
`ifdef TRIG_MON_EVENT_CNT_EN
  ,
  output logic [7:0]                    trig_events
`endif
);

  localparam int PW = $clog2(HIST_DEPTH);
  localparam int FW = PW + 1;

  mon_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   stamp_q, stamp_d;
  logic [FW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [FW-1:0]      fill_w;
  logic [STATE_W-1:0] rd_data;
  logic               trig_q;
  logic               trig_edge;
  logic               vld_w;
  logic               last_w;
  logic               xfer;
  logic               freeze;

  // Free-running; only rst zeroes it.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + CNT_W'(1);
  end

  // trig_q tracks trig_in even across clr, so a level
  // held through a re-arm cannot fire again.
  always_ff @(posedge clk) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig_in;
  end

  assign trig_edge = trig_in && !trig_q;
  assign freeze    = (state_q != ARMED);

  trig_hist_buf #(
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .freeze  (freeze),
    .wr_en   (state_vld),
    .wr_data (state_in),
    .rd_off  (rd_cnt_q[PW-1:0]),
    .rd_data (rd_data),
    .fill    (fill_w)
  );

  // rd_cnt_q counts beats already transferred.
  assign vld_w  = (state_q == DUMP) && (rd_cnt_q < fill_w);
  assign last_w = vld_w && (rd_cnt_q == fill_w - FW'(1));
  assign xfer   = vld_w && out_rdy;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ARMED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARMED: begin
        if (trig_edge) state_d = CAPTURED;
      end
      CAPTURED: begin
        if (dump_start) state_d = DUMP;
      end
      DUMP: begin
        if (!vld_w || (xfer && last_w))
          state_d = CAPTURED;
      end
      default: state_d = ARMED;
    endcase
    if (clr) state_d = ARMED;
  end

  always_comb begin
    out_vld    = vld_w;
    out_last   = last_w;
    out_data   = vld_w ? rd_data : '0;
    alarm      = (state_q != ARMED);
    busy       = (state_q == DUMP);
    trig_stamp = stamp_q;
    fill       = fill_w;
  end

  always_comb begin
    stamp_d  = stamp_q;
    rd_cnt_d = rd_cnt_q;
    if (state_q == ARMED && trig_edge)
      stamp_d = cnt_q;
    if (state_q == CAPTURED && dump_start)
      rd_cnt_d = '0;
    else if (xfer)
      rd_cnt_d = rd_cnt_q + FW'(1);
    if (clr) begin
      stamp_d  = '0;
      rd_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stamp_q  <= '0;
      rd_cnt_q <= '0;
    end else begin
      stamp_q  <= stamp_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

`ifdef TRIG_MON_EVENT_CNT_EN
  logic [7:0] ev_q, ev_d;

  // Counts every edge, captured or ignored; saturates.
  always_comb begin
    ev_d = ev_q;
    if (clr)
      ev_d = '0;
    else if (trig_edge && ev_q != 8'hff)
      ev_d = ev_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ev_q <= '0;
    else     ev_q <= ev_d;
  end

  assign trig_events = ev_q;
`endif

endmodule

// File: tb/tb_trig_activation_monitor.sv
// tb_trig_activation_monitor: randomized self-checking
// bench against a queue-based history/timestamp model.
module tb_trig_activation_monitor;

  localparam int D  = 4;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] state_in = '0;
  logic         state_vld = 1'b0;
  logic         trig_in = 1'b0;
  logic         clr = 1'b0;
  logic         dump_start = 1'b0;
  logic [127:0] out_data;
  logic         out_vld;
  logic         out_rdy = 1'b0;
  logic         out_last;
  logic         alarm;
  logic [CW-1:0] trig_stamp;
  logic [2:0]   fill;
  logic         busy;
`ifdef TRIG_MON_EVENT_CNT_EN
  logic [7:0]   trig_events;
`endif

  trig_activation_monitor #(
    .HIST_DEPTH (D),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state_in   (state_in),
    .state_vld  (state_vld),
    .trig_in    (trig_in),
    .clr        (clr),
    .dump_start (dump_start),
    .out_data   (out_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_last   (out_last),
    .alarm      (alarm),
    .trig_stamp (trig_stamp),
    .fill       (fill),
    .busy       (busy)
`ifdef TRIG_MON_EVENT_CNT_EN
    ,
    .trig_events (trig_events)
`endif
  );

  always #5 clk = ~clk;

  int n_edges = 0;
  always @(posedge clk) n_edges <= n_edges + 1;

  int passed = 0;
  int total  = 0;

  // Reference model
  int           base = 0;
  bit           armed_m = 1'b1;
  logic [127:0] hist_m [$];
  logic [CW-1:0] exp_stamp = '0;
  int           ev_m = 0;

  // Captured dump
  logic [127:0] got_q [$];
  bit           last_q [$];
  int           stall_err;
  int           busy_cyc;
  bit           dump_to;

  function automatic int cnt_m();
    return (n_edges - base) % (1 << CW);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int stream_errs();
    int e = 0;
    if (got_q.size() != hist_m.size()) e++;
    for (int i = 0; i < got_q.size(); i++) begin
      if (i >= hist_m.size()) e++;
      else begin
        if (got_q[i] !== hist_m[i]) e++;
        if (last_q[i] != (i == hist_m.size() - 1)) e++;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_m(input logic [127:0] s);
    if (armed_m) begin
      hist_m.push_back(s);
      if (hist_m.size() > D) void'(hist_m.pop_front());
    end
  endtask

  task automatic model_arm();
    armed_m = 1'b1;
    hist_m.delete();
    exp_stamp = '0;
    ev_m = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    base = n_edges;
    model_arm();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_arm();
  endtask

  task automatic load(input logic [127:0] s);
    state_in = s;
    state_vld = 1'b1;
    push_m(s);
    tick();
    state_vld = 1'b0;
  endtask

  task automatic fire(input bit vld, input logic [127:0] s);
    trig_in = 1'b1;
    if (vld) begin
      state_in = s;
      state_vld = 1'b1;
      push_m(s);
    end
    if (armed_m) begin
      exp_stamp = CW'(cnt_m());
      armed_m = 1'b0;
    end
    if (ev_m < 255) ev_m++;
    tick();
    trig_in = 1'b0;
    state_vld = 1'b0;
    tick();
  endtask

  task automatic do_dump(input int mode);
    logic [127:0] held;
    bit stalled;
    int k;
    got_q.delete();
    last_q.delete();
    stall_err = 0;
    busy_cyc = 0;
    dump_to = 1'b0;
    stalled = 1'b0;
    held = '0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    k = 0;
    while (busy && k < 200) begin
      busy_cyc++;
      case (mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = (k % 3 == 0);
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      if (stalled && (!out_vld || out_data !== held))
        stall_err++;
      if (out_vld && out_rdy) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      stalled = out_vld && !out_rdy;
      held = out_data;
      tick();
      k++;
    end
    out_rdy = 1'b0;
    if (k >= 200) dump_to = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_vld !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rst_flags: vld=%b last=%b busy=%b want 0", out_vld, out_last, busy);
    end else passed++;
    total++;
    if (alarm !== 1'b0) $display("FAIL rst_alarm: got %b want 0", alarm);
    else passed++;
    total++;
    if (trig_stamp !== '0) $display("FAIL rst_stamp: got %0d want 0", trig_stamp);
    else passed++;
    total++;
    if (fill !== 3'd0) $display("FAIL rst_fill: got %0d want 0", fill);
    else passed++;
    total++;
    if (out_data !== '0) $display("FAIL rst_data: got %h want 0", out_data);
    else passed++;
`ifdef TRIG_MON_EVENT_CNT_EN
    total++;
    if (trig_events !== 8'd0) $display("FAIL rst_events: got %0d want 0", trig_events);
    else passed++;
`endif
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 1; i <= 6; i++) load(128'(i));
    while (cnt_m() != 100) tick();
    total++;
    if (alarm !== 1'b0) $display("FAIL t1_pre_alarm: got %b want 0", alarm);
    else passed++;
    trig_in = 1'b1;
    exp_stamp = CW'(cnt_m());
    armed_m = 1'b0;
    ev_m++;
    tick();
    trig_in = 1'b0;
    total++;
    if (alarm !== 1'b1) $display("FAIL t1_alarm: got %b want 1", alarm);
    else passed++;
    total++;
    if (trig_stamp !== 8'd100) $display("FAIL t1_stamp: got %0d want 100", trig_stamp);
    else passed++;
    total++;
    if (fill !== 3'd4) $display("FAIL t1_fill: got %0d want 4", fill);
    else passed++;
    tick();
    do_dump(0);
    total++;
    if (dump_to || stream_errs() != 0)
      $display("FAIL t1_stream: beats %0d errs %0d timeout %b want 4 beats 0x3..0x6", got_q.size(), stream_errs(), dump_to);
    else passed++;
    total++;
    if (got_q.size() != 4 || got_q[3] !== 128'h6)
      $display("FAIL t1_last_entry: beats %0d want 4 ending 0x6", got_q.size());
    else passed++;
    total++;
    if (out_vld !== 1'b0 || busy !== 1'b0 || alarm !== 1'b1)
      $display("FAIL t1_post: vld=%b busy=%b alarm=%b want 0 0 1", out_vld, busy, alarm);
    else passed++;
  endtask

  task automatic test_hold();
    int n;
    do_clr();
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) load(rnd128());
    trig_in = 1'b1;
    exp_stamp = CW'(cnt_m());
    armed_m = 1'b0;
    ev_m++;
    repeat (20) tick();
    trig_in = 1'b0;
    repeat ($urandom_range(1, 4)) tick();
    fire(0, '0);
    total++;
    if (trig_stamp !== exp_stamp)
      $display("FAIL t2_stamp: got %0d want %0d", trig_stamp, exp_stamp);
    else passed++;
    total++;
    if (alarm !== 1'b1) $display("FAIL t2_alarm: got %b want 1", alarm);
    else passed++;
`ifdef TRIG_MON_EVENT_CNT_EN
    total++;
    if (trig_events !== 8'(ev_m))
      $display("FAIL t2_events: got %0d want %0d", trig_events, ev_m);
    else passed++;
`endif
    do_dump(2);
    total++;
    if (dump_to || stall_err != 0 || stream_errs() != 0)
      $display("FAIL t2_stream: beats %0d errs %0d stall %0d want %0d beats", got_q.size(), stream_errs(), stall_err, hist_m.size());
    else passed++;
  endtask

  task automatic test_stall();
    logic [127:0] first [$];
    int n;
    do_clr();
    n = $urandom_range(4, 7);
    for (int i = 0; i < n; i++) load(rnd128());
    repeat ($urandom_range(0, 3)) tick();
    fire(0, '0);
    do_dump(1);
    total++;
    if (stall_err != 0) $display("FAIL t3_stable: got %0d stall changes want 0", stall_err);
    else passed++;
    total++;
    if (dump_to || got_q.size() != 4 || stream_errs() != 0)
      $display("FAIL t3_stream: beats %0d errs %0d want 4 beats", got_q.size(), stream_errs());
    else passed++;
    total++;
    if (busy !== 1'b0 || alarm !== 1'b1)
      $display("FAIL t3_state: busy=%b alarm=%b want 0 1", busy, alarm);
    else passed++;
    first = got_q;
    do_dump(1);
    total++;
    if (dump_to || got_q.size() != first.size() || stream_errs() != 0)
      $display("FAIL t3_repeat: beats %0d errs %0d want %0d beats", got_q.size(), stream_errs(), first.size());
    else passed++;
  endtask

  task automatic test_clr_abort();
    do_clr();
    for (int i = 0; i < 5; i++) load(rnd128());
    fire(0, '0);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    out_rdy = 1'b1;
    tick();
    total++;
    if (out_vld !== 1'b1 || out_data !== hist_m[1])
      $display("FAIL t4_beat2: vld=%b data=%h want 1 %h", out_vld, out_data, hist_m[1]);
    else passed++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    out_rdy = 1'b0;
    model_arm();
    total++;
    if (out_vld !== 1'b0 || alarm !== 1'b0 || busy !== 1'b0)
      $display("FAIL t4_abort: vld=%b alarm=%b busy=%b want 0", out_vld, alarm, busy);
    else passed++;
    total++;
    if (fill !== 3'd0 || trig_stamp !== '0)
      $display("FAIL t4_clear: fill=%0d stamp=%0d want 0 0", fill, trig_stamp);
    else passed++;
    repeat ($urandom_range(2, 9)) tick();
    fire(0, '0);
    total++;
    if (alarm !== 1'b1 || trig_stamp !== exp_stamp)
      $display("FAIL t4_rearm: alarm=%b stamp=%0d want 1 %0d", alarm, trig_stamp, exp_stamp);
    else passed++;
  endtask

  task automatic test_coincident();
    do_clr();
    trig_in = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_arm();
    repeat (3) tick();
    total++;
    if (alarm !== 1'b0) $display("FAIL t5_clr_edge: alarm=%b want 0", alarm);
    else passed++;
`ifdef TRIG_MON_EVENT_CNT_EN
    total++;
    if (trig_events !== 8'd0) $display("FAIL t5_clr_count: got %0d want 0", trig_events);
    else passed++;
`endif
    trig_in = 1'b0;
    tick();
    load(rnd128());
    fire(1, 128'hAA);
    total++;
    if (fill !== 3'd2) $display("FAIL t5_fill: got %0d want 2", fill);
    else passed++;
    do_dump(0);
    total++;
    if (dump_to || stream_errs() != 0 || got_q.size() == 0 || got_q[got_q.size()-1] !== 128'hAA)
      $display("FAIL t5_stream: beats %0d errs %0d want 2 ending 0xaa", got_q.size(), stream_errs());
    else passed++;
    do_clr();
    fire(0, '0);
    total++;
    if (fill !== 3'd0 || alarm !== 1'b1)
      $display("FAIL t5_empty_cap: fill=%0d alarm=%b want 0 1", fill, alarm);
    else passed++;
    do_dump(0);
    total++;
    if (got_q.size() != 0 || busy_cyc != 1)
      $display("FAIL t5_empty_dump: beats %0d busy %0d want 0 1", got_q.size(), busy_cyc);
    else passed++;
  endtask

  task automatic test_wrap_rst();
    int k = 0;
    do_clr();
    load(rnd128());
    load(rnd128());
    while (cnt_m() != (1 << CW) - 2 && k < 600) begin
      tick();
      k++;
    end
    repeat (3) tick();
    fire(0, '0);
    total++;
    if (trig_stamp !== 8'd1) $display("FAIL t6_wrap: got %0d want 1", trig_stamp);
    else passed++;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    total++;
    if (busy !== 1'b1 || out_vld !== 1'b1)
      $display("FAIL t6_in_dump: busy=%b vld=%b want 1 1", busy, out_vld);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = n_edges;
    model_arm();
    total++;
    if (out_vld !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || alarm !== 1'b0 || out_data !== '0)
      $display("FAIL t6_rst_flags: vld=%b last=%b busy=%b alarm=%b want 0", out_vld, out_last, busy, alarm);
    else passed++;
    total++;
    if (fill !== 3'd0 || trig_stamp !== '0)
      $display("FAIL t6_rst_regs: fill=%0d stamp=%0d want 0 0", fill, trig_stamp);
    else passed++;
    repeat (5) tick();
    fire(0, '0);
    total++;
    if (trig_stamp !== exp_stamp)
      $display("FAIL t6_post_rst_stamp: got %0d want %0d", trig_stamp, exp_stamp);
    else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_stall();
    test_clr_abort();
    test_coincident();
    test_wrap_rst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
